// File: rtl/accum_sched_if.sv
// Request/response bundle between the per-channel requesters and accum_sched.
// The master side drives requests and consumes responses; accum_sched is the slave.
interface accum_sched_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_bypass;
  logic [NREQ-1:0]       req_load;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;

  modport master (
    output req_valid, req_data, req_bypass, req_load, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_bypass, req_load, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/accum_sched.sv
// Round-robin scheduler sharing one accumulate datapath among NREQ requesters,
// each with a private context; results return through one registered response slot.
module accum_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_all,
  output logic          busy,
  accum_sched_if.slave  bus
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   init_idx_q, init_idx_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] ctx_q [NREQ];
  logic [WIDTH-1:0] ctx_d [NREQ];

  logic             slot_free;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_oh;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  int               cand;

  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ctx_d       = ctx_q;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    operand     = '0;
    result      = '0;
    cand        = 0;
    slot_free   = !rsp_valid_q || bus.rsp_ready;

    // Search from rr_ptr upward; the first valid requester wins.
    if (state_q == S_RUN && slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (int'(rr_ptr_q) + k) % NREQ;
        if (!grant_vld && bus.req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = IDW'(cand);
        end
      end
    end

    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
      operand = bus.req_data[int'(grant_idx)*WIDTH +: WIDTH];
      if (bus.req_bypass[grant_idx]) begin
        result = operand;
      end else if (bus.req_load[grant_idx]) begin
        result = operand;
        ctx_d[grant_idx] = operand;
      end else begin
        result = wrap_add(ctx_q[grant_idx], operand);
        ctx_d[grant_idx] = result;
      end
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = result;
      rr_ptr_d    = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    // A clear during RUN lets the current grant finish; INIT zeroes afterwards.
    case (state_q)
      S_INIT: begin
        ctx_d[init_idx_q] = '0;
        if (clear_all) begin
          init_idx_d = '0;
        end else if (init_idx_q == IDW'(NREQ-1)) begin
          init_idx_d = '0;
          state_d    = S_RUN;
        end else begin
          init_idx_d = init_idx_q + IDW'(1);
        end
      end
      default: begin
        if (clear_all) begin
          init_idx_d = '0;
          state_d    = S_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Context storage is data only; INIT is what makes it defined.
  always_ff @(posedge clk) begin
    ctx_q <= ctx_d;
  end

  assign busy          = (state_q == S_INIT);
  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_accum_sched.sv
// Bench for accum_sched: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a behavioural scheduler model.
module tb_accum_sched;
  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int IDW   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_all = 1'b0;
  logic busy;

  accum_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus();

  accum_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (clear_all),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ld;
    logic [1:0]  byp;
    logic        rr;
    logic [1:0]  e_ready;
    logic        e_rv;
    logic        e_id;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] ld, input logic [1:0] byp, input logic rr,
                       input logic clr);
    bus.req_valid  = v;
    bus.req_data   = {d1, d0};
    bus.req_load   = ld;
    bus.req_bypass = byp;
    bus.rsp_ready  = rr;
    clear_all      = clr;
  endtask

  // One cycle: drive at negedge, check combinational grant and busy, cross the edge.
  task automatic apply(input string tag, input logic [1:0] v, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] ld, input logic [1:0] byp,
                       input logic rr, input logic clr, input logic [1:0] e_ready,
                       input logic e_busy);
    @(negedge clk);
    drive(v, d0, d1, ld, byp, rr, clr);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(e_ready));
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic rv, input logic id, input logic [31:0] data);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    if (rv) begin
      chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(id));
      chk({tag, "_rsp_data"}, bus.rsp_data, data);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  // Reset is released between edges; the following edges run the init sequence.
  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_random(input int ncyc);
    logic [31:0] m_ctx [NREQ];
    int          m_busy_left;
    int          m_ptr;
    logic        m_rv;
    logic        m_id;
    logic [31:0] m_data;
    logic [1:0]  v, ld, byp;
    logic [31:0] d [NREQ];
    logic        rr, clr;
    int          g, c;
    logic [1:0]  e_rdy;

    for (int i = 0; i < NREQ; i++) m_ctx[i] = '0;
    m_busy_left = NREQ;
    m_ptr = 0;
    m_rv = 1'b0;
    m_id = 1'b0;
    m_data = '0;

    @(negedge clk);
    drive(2'b11, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rnd_reset");
    release_reset();

    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      v   = 2'($urandom_range(3));
      ld  = {($urandom_range(4) == 0), ($urandom_range(4) == 0)};
      byp = {($urandom_range(6) == 0), ($urandom_range(6) == 0)};
      rr  = ($urandom_range(9) < 7);
      clr = ($urandom_range(49) == 0);
      for (int i = 0; i < NREQ; i++)
        d[i] = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(50));
      drive(v, d[0], d[1], ld, byp, rr, clr);

      g = -1;
      if (m_busy_left == 0 && (!m_rv || rr)) begin
        for (int k = 0; k < NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (g < 0 && v[c]) g = c;
        end
      end
      e_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      #1;
      chk("rnd_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("rnd_busy", 32'(busy), 32'(m_busy_left != 0));

      @(posedge clk);
      #1;
      if (g >= 0) begin
        if (byp[g]) begin
          m_data = d[g];
        end else if (ld[g]) begin
          m_data = d[g];
          m_ctx[g] = d[g];
        end else begin
          m_data = m_ctx[g] + d[g];
          m_ctx[g] = m_data;
        end
        m_rv = 1'b1;
        m_id = 1'(g);
        m_ptr = (g + 1) % NREQ;
      end else if (rr) begin
        m_rv = 1'b0;
      end
      if (clr) begin
        m_busy_left = NREQ;
        for (int i = 0; i < NREQ; i++) m_ctx[i] = '0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
      end
      chk_rsp("rnd", m_rv, m_id, m_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed normally");
    $fatal(1, "watchdog");
  end

  initial begin
    //        v      d0            d1            ld     byp    rr    ready  rv    id    data
    tbl[0]  = '{2'b01, 32'd5,        32'd0,        2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 32'h5};
    tbl[1]  = '{2'b11, 32'd5,        32'd100,      2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'd100};
    tbl[2]  = '{2'b11, 32'd5,        32'd100,      2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 32'd10};
    tbl[3]  = '{2'b11, 32'd5,        32'd100,      2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'd200};
    tbl[4]  = '{2'b11, 32'd5,        32'd100,      2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 32'd15};
    tbl[5]  = '{2'b10, 32'd0,        32'hFFFF_FFF0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFF0};
    tbl[6]  = '{2'b10, 32'd0,        32'h20,       2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'h10};
    tbl[7]  = '{2'b10, 32'd0,        32'd7,        2'b00, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 32'd7};
    tbl[8]  = '{2'b10, 32'd0,        32'd1,        2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'h11};
    tbl[9]  = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 32'h10};
    tbl[10] = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 32'h10};
    tbl[11] = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 32'h10};
    tbl[12] = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 32'h10};
    tbl[13] = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 32'h10};
    tbl[14] = '{2'b11, 32'd1,        32'd1,        2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 32'h12};
    tbl[15] = '{2'b00, 32'd0,        32'd0,        2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0};

    drive(2'b11, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    release_reset();
    apply("init0", 2'b11, 32'd5, 32'd100, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    apply("init1", 2'b11, 32'd5, 32'd100, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].ld, tbl[i].byp,
            tbl[i].rr, 1'b0, tbl[i].e_ready, 1'b0);
      chk_rsp($sformatf("tbl%0d", i), tbl[i].e_rv, tbl[i].e_id, tbl[i].e_data);
    end

    // clear_all coinciding with a grant to requester 1
    apply("clr_load", 2'b01, 32'd42, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    chk_rsp("clr_load", 1'b1, 1'b0, 32'd42);
    apply("clr_grant", 2'b10, 32'd0, 32'd3, 2'b00, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    chk_rsp("clr_grant", 1'b1, 1'b1, 32'h15);
    apply("clr_init0", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    chk_rsp("clr_init0", 1'b0, 1'b0, 32'd0);
    apply("clr_init1", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    apply("clr_add0", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    chk_rsp("clr_add0", 1'b1, 1'b0, 32'd1);
    apply("clr_add1", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    chk_rsp("clr_add1", 1'b1, 1'b1, 32'd1);

    // asynchronous reset while a response is pending
    apply("mid_grant", 2'b01, 32'd9, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    chk_rsp("mid_grant", 1'b1, 1'b0, 32'd10);
    drive(2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    release_reset();
    apply("mid_init0", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    apply("mid_init1", 2'b11, 32'd1, 32'd1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    apply("mid_add0", 2'b01, 32'd1, 32'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    chk_rsp("mid_add0", 1'b1, 1'b0, 32'd1);

    run_random(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/accum_sched.md
# accum_sched

Round-robin scheduler that shares one accumulate datapath among `NREQ` requesters. Each requester owns a private accumulator context, held in a context register file inside this block. The block grants at most one operation per cycle and applies add, load or bypass to the granted requester's context. It returns the result through a single registered response slot with backpressure. It sits between per-channel traffic generators and the shared accumulate engine, and replaces per-channel accumulator instances.

## Interface
Parameters:
- `NREQ`, 2 — number of requesters; must be ≥ 2.
- `WIDTH`, 32 — data and context width.
- `IDW`, `$clog2(NREQ)` — width of the requester index.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `clear_all`  in  1  — one-cycle pulse; re-zeroes every context.
- `req_valid`  in  NREQ  — per-requester operation request.
- `req_ready`  out  NREQ  — grant; a transfer happens when `req_valid[i] & req_ready[i]`.
- `req_data`  in  NREQ*WIDTH  — operand; slice i belongs to requester i.
- `req_bypass`  in  NREQ  — return the operand and leave the context unchanged.
- `req_load`  in  NREQ  — overwrite the context with the operand instead of adding.
- `rsp_valid`  out  1  — response slot holds a result.
- `rsp_ready`  in  1  — consumer accepts the response.
- `rsp_id`  out  IDW  — requester index of the response.
- `rsp_data`  out  WIDTH  — result value.
- `busy`  out  1  — high while in the INIT state.

## Operation
State machine:
- States: INIT, RUN.
- INIT: writes 0 to context `init_idx`, then increments `init_idx`. All `req_ready` are 0 in this state. The state moves to RUN after the write to context NREQ-1.
- RUN: normal arbitration.
- `clear_all` seen in RUN: `init_idx` is set to 0 and the state moves to INIT on the next edge.
- `clear_all` seen in INIT: `init_idx` restarts at 0.
- A pending response in the slot is kept across INIT and still drains normally.

Arbitration:
- Pointer `rr_ptr` selects the first requester to consider.
- Candidates are requesters with `req_valid` set, searched from `rr_ptr` upward, modulo NREQ.
- A grant is given only in RUN and only when `slot_free = !rsp_valid | rsp_ready`.
- `req_ready` is one-hot or zero. It is combinational from `req_valid`, `rr_ptr`, state, `rsp_valid` and `rsp_ready`.
- `req_ready` does not depend on `req_data`.
- On a grant to requester g, `rr_ptr` becomes `(g+1) mod NREQ`. Without a grant, `rr_ptr` holds.

Operation on grant g with operand d and context c:
- bypass (takes priority over load): result = d; context unchanged.
- load: result = d; context ← d.
- otherwise: result = c + d, truncated to WIDTH bits (wraps, no carry out); context ← result.

Response slot:
- Loads `{g, result}` and sets `rsp_valid` on the grant edge.
- Clears `rsp_valid` when `rsp_ready` is high and there is no new grant.
- Accepting the old response and loading a new one in the same cycle is allowed (full throughput).

Reset (`rst_n` low, asynchronous):
- state = INIT; `init_idx` = 0; `rr_ptr` = 0.
- `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
- Contexts are not reset directly; INIT zeroes them.
- `busy` = 1, `req_ready` = 0.

## Timing
- Init latency: NREQ cycles after `rst_n` deasserts, or after the `clear_all` edge. `busy` falls with the transition to RUN.
- Operation latency: the response is visible in the cycle after the grant edge.
- Throughput: one operation per cycle while `rsp_ready` stays high.
- Back-to-back grants to the same requester see the updated context. The context write and the slot load happen on the same edge, with no forwarding hazard.
- `rsp_ready` low with `rsp_valid` high: no grants; `rsp_id` and `rsp_data` hold stable.
- `req_valid` may drop without a grant; no state is affected.
- `clear_all` on the same cycle as a grant: the grant completes, its response is delivered, and then INIT zeroes every context, including the one just written.
- Reset mid-operation: the pending response is discarded and all outputs take their reset values immediately.

## Test plan
- Reset, then `NREQ`=2: `busy` stays high for exactly 2 cycles with `req_ready`=0; the first add of 5 from requester 0 returns `rsp_data`=5, `rsp_id`=0.
- Both requesters hold `req_valid` continuously, with `rsp_ready`=1, adding 5 (req0) and 100 (req1): grants alternate 0,1,0,1; responses are 5, 100, 10, 200.
- Requester 1 context 0xFFFF_FFF0, add 0x20: `rsp_data`=0x10 and the context wraps. Then bypass with 7: response 7, and a following add of 1 returns 0x11.
- `rsp_ready`=0 for 4 cycles with both requesters valid: exactly one response is held stable, no `req_ready` pulses occur, and the correct values resume on release.
- Load 42 into req0, then pulse `clear_all` in the same cycle as a req1 grant: the req1 response is delivered, `busy` is high for 2 cycles, and the next add of 1 to each requester returns 1.
- Assert `rst_n` low while `rsp_valid`=1: `rsp_valid` drops immediately and the re-init sequence repeats.
